sample_test_pipe: RTL and testbench
===================================

Name: sample_test_pipe

Overview:
- Point-in-triangle test stage of the rasterizer. Sits directly downstream of the sample iterator and upstream of the fragment consumer and the sample-count scoreboard.
- Accepts one triangle/sample pair per cycle at R16. Evaluates three edge functions in fixed point. Emits the hit fragment at R18, two pipeline stages later, with downstream halt support.

Parameters:
SIGFIG, 24, bits in color and position words
RADIX, 10, fraction bits in position/color
VERTS, 3, vertices per triangle
AXIS, 3, axes per vertex (x,y,z)
COLORS, 3, color channels

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
tri_R16S  input  signed [SIGFIG-1:0] x [VERTS][AXIS]  triangle vertices
color_R16U  input  [SIGFIG-1:0] x [COLORS]  triangle color
sample_R16S  input  signed [SIGFIG-1:0] x [2]  sample position (x,y)
validSamp_R16H  input  1  sample valid
halt_RnnnnL  input  1  active-low downstream halt; 0 freezes the pipe
hit_R18S  output  signed [SIGFIG-1:0] x [AXIS]  fragment {sample x, sample y, v0 z}
color_R18U  output  [SIGFIG-1:0] x [COLORS]  fragment color
hit_valid_R18H  output  1  fragment valid

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Two register stages, R16->R17->R18. Latency is 2 enabled cycles. Throughput is 1 per cycle.
- Stage R16->R17:
  - Compute shifted vertices v_i' = v_i(x,y) - sample, SIGFIG+1 bits signed.
  - Register v_i', sample, v0 z, color and valid.
- Stage R17->R18:
  - dist_i = x_i'*y_(i+1)' - x_(i+1)'*y_i', with i+1 taken mod 3.
  - Products are 2*SIGFIG+2 bits signed; the difference is 2*SIGFIG+3 bits signed. There is no truncation or saturation.
  - hit = (dist0 <= 0) && (dist1 < 0) && (dist2 <= 0). This is the tie-break rule: edges 0 and 2 are inclusive, edge 1 is exclusive.
  - Triangles arrive clockwise and back-face culled; no orientation correction is applied.
- hit_valid_R18H = registered valid && hit. hit_R18S and color_R18U are registered every enabled cycle, regardless of hit.
- Enable = halt_RnnnnL:
  - When 0, every pipeline register, including valid, holds its value. Outputs stay stable for the full halt.
  - Inputs presented during a halt are not captured; upstream holds them.
- Halt released: the pipe advances on the first clk edge with halt_RnnnnL=1. No sample is dropped or duplicated.
- Reset:
  - All data registers go to 0; both valid bits go to 0; hit_valid_R18H=0, hit_R18S=0, color_R18U=0.
  - rst has priority over halt.
  - rst mid-operation discards in-flight samples. The first new sample appears 2 cycles after rst deasserts, assuming no halt.
- Back-to-back samples of the same or different triangles need no bubble.
- validSamp_R16H=0 propagates as a bubble. Data is still registered but don't-care.

Optional Feature:
Macro SAMPLE_TEST_PERF_CNT_EN.
- When defined, adds two outputs:
  - smpl_cnt_RnnU (32 bit): counts enabled cycles with the registered R18 valid-sample bit set.
  - hit_cnt_RnnU (32 bit): counts enabled cycles with hit_valid_R18H=1.
- Both counters increment on the same edge the R18 result advances, saturate at 0xFFFFFFFF, and reset to 0.
- When undefined, the ports and logic are absent. Core behaviour is identical either way.

Test Plan:
- Inside: tri (0,0),(0,4096),(4096,0) with z=512, sample (1024,1024), valid=1, halt=1 -> 2 cycles later hit_valid_R18H=1 and hit_R18S=(1024,1024,512).
- Outside and exclusive edge: same tri with sample (4096,4096) -> hit_valid=0. Sample (2048,2048) (dist1=0, exclusive edge 1) -> hit_valid=0.
- Inclusive edge: same tri with sample (0,2048) (dist0=0) -> hit_valid=1 with hit_R18S=(0,2048,512).
- Halt: stream the 3 samples above back-to-back, then drive halt_RnnnnL=0 for 3 cycles starting the cycle after the first result. Outputs must hold for 3 cycles, then the results follow in order 1,0,1 with no loss or duplication.
- Reset: assert rst for 1 cycle with 2 valid samples in flight -> outputs 0 the next cycle, no stale hit_valid. A new sample issued after reset appears 2 cycles later.
- Perf counters (SAMPLE_TEST_PERF_CNT_EN): 10 valid samples, 4 of them hits -> smpl_cnt=10, hit_cnt=4. Preload near max through a bench force and apply 2 more hits -> hit_cnt saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/sample_test_pipe.sv
// sample_test_pipe: point-in-triangle test stage of the rasterizer.
// Takes one triangle/sample pair per cycle at R16, evaluates the three edge
// functions at full precision and presents the fragment at R18, two enabled
// cycles later. halt_RnnnnL=0 freezes every register in the pipe.
// Optional build macro: SAMPLE_TEST_PERF_CNT_EN adds saturating 32-bit
// sample/hit counters (smpl_cnt_RnnU, hit_cnt_RnnU).
module sample_test_pipe #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R16S    [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R16U  [COLORS],
  input  logic signed [SIGFIG-1:0] sample_R16S [2],
  input  logic                     validSamp_R16H,
  input  logic                     halt_RnnnnL,
  output logic signed [SIGFIG-1:0] hit_R18S    [AXIS],
  output logic        [SIGFIG-1:0] color_R18U  [COLORS],
  output logic                     hit_valid_R18H
`ifdef SAMPLE_TEST_PERF_CNT_EN
  ,
  output logic        [31:0]       smpl_cnt_RnnU,
  output logic        [31:0]       hit_cnt_RnnU
`endif
);

  // Shifted vertex width, cross-product width and edge-distance width.
  localparam int SW = SIGFIG + 1;
  localparam int PW = 2 * SIGFIG + 2;
  localparam int DW = 2 * SIGFIG + 3;

  function automatic logic signed [SW-1:0] sext(input logic signed [SIGFIG-1:0] a);
    return {a[SIGFIG-1], a};
  endfunction

  // Edge function xa*yb - xb*ya, kept at full width so the sign is exact.
  function automatic logic signed [DW-1:0] edge_dist(input logic signed [SW-1:0] xa,
                                                     input logic signed [SW-1:0] ya,
                                                     input logic signed [SW-1:0] xb,
                                                     input logic signed [SW-1:0] yb);
    logic signed [PW-1:0] p_a;
    logic signed [PW-1:0] p_b;
    p_a = PW'(xa) * PW'(yb);
    p_b = PW'(xb) * PW'(ya);
    return DW'(p_a) - DW'(p_b);
  endfunction

`ifdef SAMPLE_TEST_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic inc);
    if (inc && (cnt != 32'hFFFF_FFFF)) return cnt + 32'd1;
    return cnt;
  endfunction
`endif

  logic signed [SW-1:0]     w_vx_p0   [VERTS];
  logic signed [SW-1:0]     w_vy_p0   [VERTS];
  logic                     w_unused_p0;

  logic signed [SW-1:0]     r_vx_p1   [VERTS];
  logic signed [SW-1:0]     r_vy_p1   [VERTS];
  logic signed [SIGFIG-1:0] r_smp_p1  [2];
  logic signed [SIGFIG-1:0] r_z_p1;
  logic        [SIGFIG-1:0] r_col_p1  [COLORS];
  logic                     r_vld_p1;

  logic signed [DW-1:0]     w_dist_p1 [VERTS];
  logic                     w_hit_p1;

  logic signed [SIGFIG-1:0] r_hit_p2  [AXIS];
  logic        [SIGFIG-1:0] r_col_p2  [COLORS];
  logic                     r_hitvld_p2;

  // Only v0 supplies the fragment depth; the other z values and the colour
  // radix do not affect the inside/outside decision.
  assign w_unused_p0 = ^{tri_R16S[1][2], tri_R16S[2][2], 32'(RADIX)};

  // ---- R16: translate the triangle so the sample sits at the origin ----
  // Shift each vertex by the sample position, one extra bit of headroom.
  always_comb begin
    for (int i = 0; i < VERTS; i++) begin
      w_vx_p0[i] = sext(tri_R16S[i][0]) - sext(sample_R16S[0]);
      w_vy_p0[i] = sext(tri_R16S[i][1]) - sext(sample_R16S[1]);
    end
  end

  // ---- R16 -> R17 boundary ----
  // Capture shifted vertices, sample, v0 depth, colour and valid when enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < VERTS; i++) begin
        r_vx_p1[i] <= '0;
        r_vy_p1[i] <= '0;
      end
      r_smp_p1[0] <= '0;
      r_smp_p1[1] <= '0;
      r_z_p1      <= '0;
      for (int c = 0; c < COLORS; c++) r_col_p1[c] <= '0;
      r_vld_p1    <= 1'b0;
    end else if (halt_RnnnnL) begin
      for (int i = 0; i < VERTS; i++) begin
        r_vx_p1[i] <= w_vx_p0[i];
        r_vy_p1[i] <= w_vy_p0[i];
      end
      r_smp_p1[0] <= sample_R16S[0];
      r_smp_p1[1] <= sample_R16S[1];
      r_z_p1      <= tri_R16S[0][2];
      for (int c = 0; c < COLORS; c++) r_col_p1[c] <= color_R16U[c];
      r_vld_p1    <= validSamp_R16H;
    end
  end

  // ---- R17: edge functions and tie-break ----
  // dist_i pairs vertex i with vertex i+1 (wrapping back to v0).
  always_comb begin
    for (int i = 0; i < VERTS; i++) begin
      w_dist_p1[i] = edge_dist(r_vx_p1[i], r_vy_p1[i],
                               r_vx_p1[(i + 1) % VERTS], r_vy_p1[(i + 1) % VERTS]);
    end
  end

  // Clockwise triangles: inside means non-positive distances. Edges 0 and 2
  // own their boundary, edge 1 does not, so shared edges hit exactly once.
  assign w_hit_p1 = (w_dist_p1[0][DW-1] || (w_dist_p1[0] == '0)) &&
                    w_dist_p1[1][DW-1] &&
                    (w_dist_p1[2][DW-1] || (w_dist_p1[2] == '0));

  // ---- R17 -> R18 boundary ----
  // Register the fragment every enabled cycle; validity qualifies it.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < AXIS; a++) r_hit_p2[a] <= '0;
      for (int c = 0; c < COLORS; c++) r_col_p2[c] <= '0;
      r_hitvld_p2 <= 1'b0;
    end else if (halt_RnnnnL) begin
      r_hit_p2[0] <= r_smp_p1[0];
      r_hit_p2[1] <= r_smp_p1[1];
      r_hit_p2[2] <= r_z_p1;
      for (int c = 0; c < COLORS; c++) r_col_p2[c] <= r_col_p1[c];
      r_hitvld_p2 <= r_vld_p1 && w_hit_p1;
    end
  end

  assign hit_R18S       = r_hit_p2;
  assign color_R18U     = r_col_p2;
  assign hit_valid_R18H = r_hitvld_p2;

`ifdef SAMPLE_TEST_PERF_CNT_EN
  logic [31:0] r_smpl_cnt;
  logic [31:0] r_hit_cnt;

  // Count valid samples and hits as they land in R18, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_smpl_cnt <= '0;
      r_hit_cnt  <= '0;
    end else if (halt_RnnnnL) begin
      r_smpl_cnt <= sat_inc(r_smpl_cnt, r_vld_p1);
      r_hit_cnt  <= sat_inc(r_hit_cnt, r_vld_p1 && w_hit_p1);
    end
  end

  assign smpl_cnt_RnnU = r_smpl_cnt;
  assign hit_cnt_RnnU  = r_hit_cnt;
`endif

endmodule

// File: tb/tb_sample_test_pipe.sv
// Testbench for sample_test_pipe: directed point-in-triangle cases, halt,
// reset and randomized traffic checked against an integer reference model.
// Build with SAMPLE_TEST_PERF_CNT_EN to also exercise the perf counters.
module tb_sample_test_pipe;
  localparam int SF = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic signed [SF-1:0] tri_in [3][3];
  logic        [SF-1:0] col_in [3];
  logic signed [SF-1:0] smp_in [2];
  logic                 vld_in;
  logic                 halt_n;
  logic signed [SF-1:0] hit_out [3];
  logic        [SF-1:0] col_out [3];
  logic                 hv_out;
`ifdef SAMPLE_TEST_PERF_CNT_EN
  logic [31:0]          smpl_cnt;
  logic [31:0]          hit_cnt;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic          hv;
    logic [SF-1:0] hx, hy, hz, c0, c1, c2;
  } res_t;

  res_t hist[$];
  res_t exp_r;

  sample_test_pipe dut (
    .clk            (clk),
    .rst            (rst),
    .tri_R16S       (tri_in),
    .color_R16U     (col_in),
    .sample_R16S    (smp_in),
    .validSamp_R16H (vld_in),
    .halt_RnnnnL    (halt_n),
    .hit_R18S       (hit_out),
    .color_R18U     (col_out),
    .hit_valid_R18H (hv_out)
`ifdef SAMPLE_TEST_PERF_CNT_EN
    ,
    .smpl_cnt_RnnU  (smpl_cnt),
    .hit_cnt_RnnU   (hit_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: translate to the sample, 2-D cross products in 64-bit integers.
  function automatic res_t predict();
    longint xs[3], ys[3], d[3];
    res_t   r;
    for (int i = 0; i < 3; i++) begin
      xs[i] = longint'(tri_in[i][0]) - longint'(smp_in[0]);
      ys[i] = longint'(tri_in[i][1]) - longint'(smp_in[1]);
    end
    for (int i = 0; i < 3; i++)
      d[i] = xs[i] * ys[(i + 1) % 3] - xs[(i + 1) % 3] * ys[i];
    r.hv = vld_in && (d[0] <= 0) && (d[1] < 0) && (d[2] <= 0);
    r.hx = smp_in[0];
    r.hy = smp_in[1];
    r.hz = tri_in[0][2];
    r.c0 = col_in[0];
    r.c1 = col_in[1];
    r.c2 = col_in[2];
    return r;
  endfunction

  function automatic res_t observed();
    return {hv_out, hit_out[0], hit_out[1], hit_out[2], col_out[0], col_out[1], col_out[2]};
  endfunction

  // One clock: the model records every accepted input; the visible result is
  // the one accepted one enabled edge before the most recent.
  task automatic tick();
    res_t nr = predict();
    logic r  = rst;
    logic en = halt_n;
    @(posedge clk);
    if (r) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
    end else if (en) begin
      hist.push_back(nr);
      if (hist.size() > 8) void'(hist.pop_front());
    end
    exp_r = hist[hist.size() - 2];
    #1;
  endtask

  task automatic set_tri_std();
    tri_in[0][0] = 24'sd0;    tri_in[0][1] = 24'sd0;    tri_in[0][2] = 24'sd512;
    tri_in[1][0] = 24'sd0;    tri_in[1][1] = 24'sd4096; tri_in[1][2] = 24'sd300;
    tri_in[2][0] = 24'sd4096; tri_in[2][1] = 24'sd0;    tri_in[2][2] = 24'sd700;
    col_in[0] = 24'h123456; col_in[1] = 24'hABCDEF; col_in[2] = 24'h00FF00;
  endtask

  task automatic set_sample(input int x, input int y, input logic v);
    smp_in[0] = 24'(x);
    smp_in[1] = 24'(y);
    vld_in    = v;
  endtask

  function automatic logic signed [SF-1:0] rnd_coord(input int mode);
    case (mode)
      0:       return 24'((int'($urandom_range(0, 4)) - 2) * 1024);
      1:       return 24'(int'($urandom_range(0, 16383)) - 8192);
      default: return 24'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    set_tri_std();
    set_sample(1024, 1024, 1'b1);
    rst    = 1'b1;
    halt_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (hv_out !== 1'b0) begin
        errors++; $display("FAIL reset_hit_valid: got %b expected 0", hv_out);
      end
      checks++;
      if (observed() !== res_t'('0)) begin
        errors++; $display("FAIL reset_outputs: got %h expected 0", observed());
      end
    end
    rst    = 1'b0;
    halt_n = 1'b1;
    vld_in = 1'b0;
  endtask

  task automatic test_directed_stream();
    int   sx[4] = '{1024, 4096, 2048, 0};
    int   sy[4] = '{1024, 4096, 2048, 2048};
    logic eh[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   j;
    set_tri_std();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) set_sample(sx[k], sy[k], 1'b1);
      else vld_in = 1'b0;
      tick();
      if (k == 0) begin
        checks++;
        if (hv_out !== 1'b0) begin
          errors++; $display("FAIL latency_early: got %b expected 0", hv_out);
        end
      end else if (k <= 4) begin
        j = k - 1;
        checks++;
        if (hv_out !== eh[j]) begin
          errors++; $display("FAIL directed_hit_valid[%0d]: got %b expected %b", j, hv_out, eh[j]);
        end
        checks++;
        if (hit_out[0] !== 24'(sx[j]) || hit_out[1] !== 24'(sy[j]) || hit_out[2] !== 24'sd512) begin
          errors++;
          $display("FAIL directed_hit_pos[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,512)",
                   j, hit_out[0], hit_out[1], hit_out[2], sx[j], sy[j]);
        end
      end
      checks++;
      if (observed() !== exp_r) begin
        errors++; $display("FAIL directed_model[%0d]: got %h expected %h", k, observed(), exp_r);
      end
    end
  endtask

  task automatic test_halt();
    int   ex[7] = '{1024, 1024, 1024, 1024, 4096, 0, 0};
    int   ey[7] = '{1024, 1024, 1024, 1024, 4096, 2048, 2048};
    logic eh[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    set_tri_std();
    halt_n = 1'b1;
    set_sample(1024, 1024, 1'b1);
    tick();
    set_sample(4096, 4096, 1'b1);
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (hv_out !== eh[k]) begin
        errors++; $display("FAIL halt_hit_valid[%0d]: got %b expected %b", k, hv_out, eh[k]);
      end
      checks++;
      if (hit_out[0] !== 24'(ex[k]) || hit_out[1] !== 24'(ey[k]) || hit_out[2] !== 24'sd512) begin
        errors++;
        $display("FAIL halt_hit_pos[%0d]: got (%0d,%0d,%0d) expected (%0d,%0d,512)",
                 k, hit_out[0], hit_out[1], hit_out[2], ex[k], ey[k]);
      end
      checks++;
      if (observed() !== exp_r) begin
        errors++; $display("FAIL halt_model[%0d]: got %h expected %h", k, observed(), exp_r);
      end
      // Third sample waits at the input through the halt window.
      if (k == 0) begin
        set_sample(0, 2048, 1'b1);
        halt_n = 1'b0;
      end else if (k == 3) begin
        halt_n = 1'b1;
      end else if (k == 4) begin
        vld_in = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midflight();
    set_tri_std();
    halt_n = 1'b1;
    set_sample(1024, 1024, 1'b1);
    tick();
    set_sample(0, 2048, 1'b1);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (observed() !== res_t'('0)) begin
      errors++; $display("FAIL midflight_reset_outputs: got %h expected 0", observed());
    end
    rst = 1'b0;
    set_sample(512, 512, 1'b1);
    tick();
    checks++;
    if (hv_out !== 1'b0) begin
      errors++; $display("FAIL midflight_stale_valid: got %b expected 0", hv_out);
    end
    vld_in = 1'b0;
    tick();
    checks++;
    if (hv_out !== 1'b1 || hit_out[0] !== 24'sd512 || hit_out[1] !== 24'sd512 || hit_out[2] !== 24'sd512) begin
      errors++;
      $display("FAIL midflight_new_sample: got hv=%b (%0d,%0d,%0d) expected hv=1 (512,512,512)",
               hv_out, hit_out[0], hit_out[1], hit_out[2]);
    end
  endtask

  task automatic test_random();
    int mode;
    for (int n = 0; n < 600; n++) begin
      mode = int'($urandom_range(0, 2));
      for (int v = 0; v < 3; v++)
        for (int a = 0; a < 3; a++) tri_in[v][a] = rnd_coord(mode);
      for (int c = 0; c < 3; c++) col_in[c] = 24'($urandom);
      smp_in[0] = rnd_coord(mode);
      smp_in[1] = rnd_coord(mode);
      vld_in = ($urandom_range(0, 7) != 0);
      halt_n = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (observed() !== exp_r) begin
        errors++; $display("FAIL random_model[%0d]: got %h expected %h", n, observed(), exp_r);
      end
    end
    rst    = 1'b0;
    halt_n = 1'b1;
    vld_in = 1'b0;
  endtask

`ifdef SAMPLE_TEST_PERF_CNT_EN
  task automatic test_perf_counters();
    set_tri_std();
    rst    = 1'b1;
    halt_n = 1'b1;
    vld_in = 1'b0;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (k % 3 == 0) set_sample(1024, 1024, 1'b1);
      else set_sample(4096, 4096, 1'b1);
      if (k == 5) begin
        halt_n = 1'b0;
        tick();
        tick();
        halt_n = 1'b1;
      end
      tick();
    end
    vld_in = 1'b0;
    tick();
    tick();
    checks++;
    if (smpl_cnt !== 32'd10) begin
      errors++; $display("FAIL perf_smpl_cnt: got %0d expected 10", smpl_cnt);
    end
    checks++;
    if (hit_cnt !== 32'd4) begin
      errors++; $display("FAIL perf_hit_cnt: got %0d expected 4", hit_cnt);
    end
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_hit_cnt;
    checks++;
    if (hit_cnt !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL perf_preload: got %h expected fffffffe", hit_cnt);
    end
    set_sample(1024, 1024, 1'b1);
    tick();
    tick();
    vld_in = 1'b0;
    tick();
    tick();
    checks++;
    if (hit_cnt !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL perf_hit_saturate: got %h expected ffffffff", hit_cnt);
    end
    checks++;
    if (smpl_cnt !== 32'd12) begin
      errors++; $display("FAIL perf_smpl_after: got %0d expected 12", smpl_cnt);
    end
  endtask
`endif

  initial begin
    hist.push_back('0);
    hist.push_back('0);
    exp_r  = '0;
    rst    = 1'b1;
    halt_n = 1'b1;
    vld_in = 1'b0;
    set_tri_std();
    set_sample(0, 0, 1'b0);
    #2;
    test_reset();
    test_directed_stream();
    test_halt();
    test_reset_midflight();
    test_random();
`ifdef SAMPLE_TEST_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
